dl_sdram_sched: RTL and testbench

Download-write scheduler between the data_io byte stream and the two SDRAM write ports (port1: CPU/sound region, port2: graphics region). It captures each `ioctl_wr` strobe, buffers bytes in a small FIFO, and issues toggle-style req/ack transactions to one or both SDRAM ports. It then waits for completion on every targeted port before retiring the entry. It generates `rom_loaded` and `core_reset` only after the last byte is committed to SDRAM, so the core never runs on a partially written ROM image.

---
 rtl/dl_sdram_sched.sv | 236 +++++++++++++++++++++++
 tb/tb_dl_sdram_sched.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_sdram_sched.sv
`timescale 1ns/1ps
// dl_sdram_sched: takes the data_io download byte stream, buffers it in a
// small FIFO and writes each byte to SDRAM port1, and also to port2 when the
// address falls in the graphics region. rom_loaded and core_reset only
// release once the final byte has been acknowledged by every targeted port.
//
// Port handshake (both ports): a transaction is started by toggling portN_req
// while portN_a/ds/d/we are stable. The transaction is complete when the
// memory side makes portN_ack equal to portN_req. portN_req is never toggled
// again while portN_ack != portN_req. Address and data hold their values from
// the toggle until the entry retires.
module dl_sdram_sched #(
    parameter logic [7:0]  DL_INDEX   = 8'd0,
    parameter logic [24:0] GFX_BASE   = 25'h0E000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_downl,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic        port1_we,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic        port2_we,
    output logic [15:0] port2_d,
    output logic        busy,
    output logic        overflow,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic [1:0]  state_dbg
);

    localparam int            PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Strobe / download edge detection
    logic wr_last;
    logic downl_last;
    logic push;
    logic push_ok;
    logic downl_rise;
    logic downl_fall;

    // FIFO storage: {addr, data}
    logic [32:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          fifo_empty;
    logic          fifo_full;

    // Head-of-FIFO decode
    logic [24:0] head_addr;
    logic [7:0]  head_data;
    logic        head_gfx;
    logic [23:0] gfx_off;

    // Transaction bookkeeping
    logic pop;
    logic finish;
    logic t2;
    logic pending_end;
    logic p1_done;
    logic p2_done;

    assign push       = ioctl_wr & ~wr_last & ioctl_downl & (ioctl_index == DL_INDEX);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign push_ok    = push & ~fifo_full;
    assign downl_rise = ioctl_downl & ~downl_last;
    assign downl_fall = ~ioctl_downl & downl_last;

    assign head_addr = fifo_mem[rd_ptr][32:8];
    assign head_data = fifo_mem[rd_ptr][7:0];
    assign head_gfx  = (head_addr >= GFX_BASE);
    // Only bits [23:0] of the wrapped 25-bit offset reach the port.
    assign gfx_off   = head_addr[23:0] - GFX_BASE[23:0];

    assign p1_done = (port1_ack == port1_req);
    assign p2_done = (port2_ack == port2_req);

    assign busy      = ~fifo_empty | (state_q == S_WAIT);
    assign state_dbg = state_q;

    // Input history for edge detection; tracks the inputs even during reset.
    always_ff @(posedge clk_sys) begin
        wr_last    <= ioctl_wr;
        downl_last <= ioctl_downl;
    end

    // FIFO storage write; contents are only meaningful below count.
    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle keep count.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: launch the head entry, wait for every targeted ack,
    // and flag completion once the download has ended and everything drained.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_WAIT;
                end else if (!ioctl_downl && pending_end) begin
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                if (p1_done && (!t2 || p2_done)) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Port request/address/data registers; reset resyncs req to ack so no
    // transaction appears pending afterwards.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            port1_req <= port1_ack;
            port2_req <= port2_ack;
            port1_a   <= '0;
            port1_ds  <= '0;
            port1_d   <= '0;
            port2_a   <= '0;
            port2_ds  <= '0;
            port2_d   <= '0;
            t2        <= 1'b0;
        end else if (pop) begin
            port1_a   <= head_addr[23:1];
            port1_ds  <= {head_addr[0], ~head_addr[0]};
            port1_d   <= {head_data, head_data};
            port1_req <= ~port1_req;
            t2        <= head_gfx;
            if (head_gfx) begin
                port2_a   <= gfx_off[23:1];
                port2_ds  <= {gfx_off[0], ~gfx_off[0]};
                port2_d   <= {head_data, head_data};
                port2_req <= ~port2_req;
            end
        end
    end

    // Status flags: sticky overflow, end-of-download tracking, write enables.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            overflow    <= 1'b0;
            pending_end <= 1'b0;
            rom_loaded  <= 1'b0;
            port1_we    <= 1'b0;
            port2_we    <= 1'b0;
        end else begin
            if (push && fifo_full) begin
                overflow <= 1'b1;
            end
            if (downl_fall) begin
                pending_end <= 1'b1;
            end else if (finish) begin
                pending_end <= 1'b0;
            end
            if (downl_rise) begin
                rom_loaded <= 1'b0;
            end else if (finish) begin
                rom_loaded <= 1'b1;
            end
            port1_we <= ioctl_downl | busy;
            port2_we <= ioctl_downl | busy;
        end
    end

    // Core reset held until the image is committed; registered.
    always_ff @(posedge clk_sys) begin
        core_reset <= reset | ~rom_loaded;
    end

endmodule

// File: tb/tb_dl_sdram_sched.sv
`timescale 1ns/1ps
// Testbench for dl_sdram_sched: randomized and directed downloads, with a
// scoreboard of expected port transactions checked by an independent monitor.
module tb_dl_sdram_sched;

    localparam logic [24:0] GFX_BASE   = 25'h0E000;
    localparam int          FIFO_DEPTH = 4;
    localparam int          EXP_W      = 67;

    // ---------------- clock / reset ----------------
    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    logic        ioctl_downl = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr    = 1'b0;
    logic [24:0] ioctl_addr  = '0;
    logic [7:0]  ioctl_dout  = '0;
    logic        port1_ack   = 1'b0;
    logic        port2_ack   = 1'b1;
    logic        port1_req, port2_req, port1_we, port2_we;
    logic [22:0] port1_a, port2_a;
    logic [1:0]  port1_ds, port2_ds;
    logic [15:0] port1_d, port2_d;
    logic        busy, overflow, rom_loaded, core_reset;
    logic [1:0]  state_dbg;

    dl_sdram_sched #(
        .DL_INDEX  (8'd0),
        .GFX_BASE  (GFX_BASE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ioctl_downl(ioctl_downl),
        .ioctl_index(ioctl_index),
        .ioctl_wr   (ioctl_wr),
        .ioctl_addr (ioctl_addr),
        .ioctl_dout (ioctl_dout),
        .port1_req  (port1_req),
        .port1_ack  (port1_ack),
        .port1_a    (port1_a),
        .port1_ds   (port1_ds),
        .port1_we   (port1_we),
        .port1_d    (port1_d),
        .port2_req  (port2_req),
        .port2_ack  (port2_ack),
        .port2_a    (port2_a),
        .port2_ds   (port2_ds),
        .port2_we   (port2_we),
        .port2_d    (port2_d),
        .busy       (busy),
        .overflow   (overflow),
        .rom_loaded (rom_loaded),
        .core_reset (core_reset),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    // Entry layout: {t2, p1_a[22:0], p1_ds[1:0], d[15:0], p2_a[22:0], p2_ds[1:0]}
    logic [EXP_W-1:0] exp_q[$];
    int n_tests   = 0;
    int n_fail    = 0;
    int issue_cnt = 0;
    bit ack_en    = 1'b0;
    int ack_min   = 0;
    int ack_max   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: what a single accepted byte must look like on the ports.
    function automatic logic [EXP_W-1:0] model(input logic [24:0] addr, input logic [7:0] data);
        logic        gfx;
        logic [24:0] off;
        logic [22:0] p2a;
        logic [1:0]  p2ds;
        gfx  = (addr >= GFX_BASE);
        off  = addr - GFX_BASE;
        p2a  = gfx ? off[23:1] : 23'd0;
        p2ds = gfx ? {off[0], ~off[0]} : 2'b00;
        return {gfx, addr[23:1], addr[0], ~addr[0], data, data, p2a, p2ds};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [EXP_W-1:0] e;
        logic p1_prev, p2_prev;
        bit   tog1, tog2;
        p1_prev = 1'b0;
        p2_prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (reset) begin
                p1_prev = port1_req;
                p2_prev = port2_req;
            end else begin
                tog1 = (port1_req !== p1_prev);
                tog2 = (port2_req !== p2_prev);
                if (tog1) begin
                    issue_cnt++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_req: port1_req toggled with no expected byte (a=0x%0h)", port1_a);
                    end else begin
                        e = exp_q.pop_front();
                        check("port1_a",      32'(port1_a),  32'(e[65:43]));
                        check("port1_ds",     32'(port1_ds), 32'(e[42:41]));
                        check("port1_d",      32'(port1_d),  32'(e[40:25]));
                        check("port2_toggle", 32'(tog2),     32'(e[66]));
                        if (e[66]) begin
                            check("port2_a",  32'(port2_a),  32'(e[24:2]));
                            check("port2_ds", 32'(port2_ds), 32'(e[1:0]));
                            check("port2_d",  32'(port2_d),  32'(e[40:25]));
                        end
                    end
                end else if (tog2) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL port2_alone: port2_req toggled without port1_req");
                end
                p1_prev = port1_req;
                p2_prev = port2_req;
            end
        end
    end

    // ---------------- ack responders ----------------
    initial begin
        int cnt, dly;
        cnt = 0;
        dly = 0;
        forever begin
            @(posedge clk_sys); #1;
            if (reset) begin
                cnt = 0;
            end else if (ack_en && port1_ack != port1_req) begin
                if (cnt >= dly) begin
                    port1_ack = port1_req;
                    cnt = 0;
                    dly = $urandom_range(ack_max, ack_min);
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin
        int cnt, dly;
        cnt = 0;
        dly = 0;
        forever begin
            @(posedge clk_sys); #1;
            if (reset) begin
                cnt = 0;
            end else if (ack_en && port2_ack != port2_req) begin
                if (cnt >= dly) begin
                    port2_ack = port2_req;
                    cnt = 0;
                    dly = $urandom_range(ack_max, ack_min);
                end else begin
                    cnt++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data, input bit accepted);
        @(posedge clk_sys); #1;
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        if (accepted) exp_q.push_back(model(addr, data));
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
    endtask

    // Keeps the FIFO from filling so every byte is guaranteed to be accepted.
    task automatic send_gated(input logic [24:0] addr, input logic [7:0] data);
        int k;
        k = 0;
        while (exp_q.size() >= FIFO_DEPTH && k < 500) begin
            @(posedge clk_sys); #1;
            k++;
        end
        check("gate_timeout", 32'(exp_q.size() >= FIFO_DEPTH), 32'd0);
        send_byte(addr, data, 1'b1);
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < budget) begin
            @(posedge clk_sys); #1;
            k++;
        end
        @(negedge clk_sys);
        check("drain", 32'(busy || exp_q.size() != 0), 32'd0);
    endtask

    function automatic logic [24:0] rand_addr();
        case ($urandom_range(4, 0))
            0:       return 25'($urandom_range(32'(GFX_BASE) - 1, 0));
            1:       return 25'($urandom_range(32'h1FFFFFF, 32'(GFX_BASE)));
            2:       return GFX_BASE - 25'd1;
            3:       return GFX_BASE;
            default: return 25'h1FFFFFF;
        endcase
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        bit early;
        int k;
        logic p2_save;

        // Reset values
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        check("rst_rom_loaded", 32'(rom_loaded), 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_port1_a",    32'(port1_a),    32'd0);
        check("rst_port2_ds",   32'(port2_ds),   32'd0);
        check("rst_port1_d",    32'(port1_d),    32'd0);
        check("rst_port1_we",   32'(port1_we),   32'd0);
        check("rst_port1_req",  32'(port1_req),  32'd0);
        check("rst_port2_req",  32'(port2_req),  32'd1);
        reset = 1'b0;
        @(posedge clk_sys); #1;
        ioctl_downl = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        check("we_during_dl", 32'(port1_we), 32'd1);

        // Port1-only routing with a 3-cycle ack
        ack_en  = 1'b1;
        ack_min = 3;
        ack_max = 3;
        p2_save = port2_req;
        base    = issue_cnt;
        send_byte(25'h00003, 8'hA5, 1'b1);
        wait_drain(50);
        check("t1_port1_a",   32'(port1_a),   32'h1);
        check("t1_port1_ds",  32'(port1_ds),  32'h2);
        check("t1_port1_d",   32'(port1_d),   32'hA5A5);
        check("t1_port2_req", 32'(port2_req), 32'(p2_save));
        check("t1_count",     32'(issue_cnt - base), 32'd1);

        // Both ports, acks at +1 and +5 after the toggle
        ack_en = 1'b0;
        send_byte(25'h0E001, 8'h3C, 1'b1);
        @(posedge clk_sys); #1;
        check("t2_p1_pending", 32'(port1_req ^ port1_ack), 32'd1);
        check("t2_p2_pending", 32'(port2_req ^ port2_ack), 32'd1);
        check("t2_port2_a",    32'(port2_a),  32'd0);
        check("t2_port2_ds",   32'(port2_ds), 32'h2);
        port1_ack = port1_req;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk_sys); #1;
            check("t2_busy_hold", 32'(busy), 32'd1);
        end
        port2_ack = port2_req;
        @(posedge clk_sys); #1;
        check("t2_retired", 32'(busy), 32'd0);

        // Overflow: acks held, six strobes, one in flight plus a full FIFO
        ack_en = 1'b0;
        base   = issue_cnt;
        for (int i = 0; i < 6; i++) begin
            send_byte(25'($urandom_range(32'(GFX_BASE) - 1, 0)), 8'($urandom), i < FIFO_DEPTH + 1);
        end
        repeat (8) @(posedge clk_sys);
        #1;
        check("ovf_flag",     32'(overflow), 32'd1);
        check("ovf_inflight", 32'(issue_cnt - base), 32'd1);
        ack_min = 0;
        ack_max = 2;
        ack_en  = 1'b1;
        wait_drain(200);
        check("ovf_count", 32'(issue_cnt - base), 32'd5);

        // Filtering: wrong index, then a strobe held high for 3 cycles
        base = issue_cnt;
        ioctl_index = 8'd1;
        send_byte(25'h00100, 8'h11, 1'b0);
        ioctl_index = 8'd0;
        repeat (4) @(posedge clk_sys);
        #1;
        check("filt_index", 32'(issue_cnt - base), 32'd0);
        ioctl_addr = 25'h00200;
        ioctl_dout = 8'h22;
        ioctl_wr   = 1'b1;
        exp_q.push_back(model(25'h00200, 8'h22));
        repeat (3) @(posedge clk_sys);
        #1;
        ioctl_wr = 1'b0;
        wait_drain(50);
        check("filt_held", 32'(issue_cnt - base), 32'd1);

        // Randomized traffic
        ack_min = 0;
        ack_max = 4;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(3, 0)) @(posedge clk_sys);
            send_gated(rand_addr(), 8'($urandom));
        end
        wait_drain(300);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Completion: 16 bytes, download ends with 2 still queued
        ack_min = 2;
        ack_max = 2;
        for (int i = 0; i < 16; i++) begin
            send_gated(rand_addr(), 8'($urandom));
        end
        k = 0;
        while (exp_q.size() > 2 && k < 200) begin
            @(posedge clk_sys); #1;
            k++;
        end
        ioctl_downl = 1'b0;
        early = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            if (rom_loaded) early = 1'b1;
            @(posedge clk_sys); #1;
            k++;
        end
        check("end_not_early", 32'(early), 32'd0);
        check("end_drained",   32'(busy),  32'd0);
        for (int j = 0; j < 2 && !rom_loaded; j++) begin
            @(posedge clk_sys); #1;
        end
        check("end_rom_loaded", 32'(rom_loaded), 32'd1);
        check("end_core_hold",  32'(core_reset), 32'd1);
        @(posedge clk_sys); #1;
        check("end_core_rel",   32'(core_reset), 32'd0);
        check("end_we_low",     32'(port1_we),   32'd0);
        check("end_queue",      32'(exp_q.size()), 32'd0);

        // Re-download clears rom_loaded
        ioctl_downl = 1'b1;
        @(posedge clk_sys); #1;
        check("redl_rom_loaded", 32'(rom_loaded), 32'd0);
        @(posedge clk_sys); #1;
        check("redl_core_reset", 32'(core_reset), 32'd1);

        // Reset with a request outstanding and a byte queued
        ack_en = 1'b0;
        send_byte(25'h0E010, 8'($urandom), 1'b1);
        @(posedge clk_sys); #1;
        check("rst6_pending", 32'(port1_req ^ port1_ack), 32'd1);
        send_byte(25'h00040, 8'($urandom), 1'b1);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk_sys);
        #1;
        check("rst6_p1_sync", 32'(port1_req), 32'(port1_ack));
        check("rst6_p2_sync", 32'(port2_req), 32'(port2_ack));
        check("rst6_busy",    32'(busy),      32'd0);
        check("rst6_ovf",     32'(overflow),  32'd0);
        check("rst6_loaded",  32'(rom_loaded), 32'd0);
        reset  = 1'b0;
        base   = issue_cnt;
        ack_en = 1'b1;
        repeat (10) @(posedge clk_sys);
        #1;
        check("rst6_quiet",      32'(issue_cnt - base), 32'd0);
        check("rst6_busy_after", 32'(busy), 32'd0);
        send_gated(25'h00123, 8'h5A);
        wait_drain(50);
        check("rst6_resume", 32'(issue_cnt - base), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
